// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding and port identifiers for the memory arbiter
package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_DM = 1'b1
    } port_t;

    // Marking the fetch port as last served gives the data port first pick after reset
    localparam port_t RESET_LAST = PORT_IF;
endpackage

// File: rtl/mem_arbiter_rr_select2.sv
// rr_select2: two-way round-robin selector, one-hot grant indexed by port_t (bit0 IF, bit1 DM)
module rr_select2
    import mem_arbiter_pkg::*;
(
    input  logic       i_req_if,
    input  logic       i_req_dm,
    input  port_t      i_last,
    output logic [1:0] o_gnt
);
    // A lone requester always wins; on contention the port not served last wins
    assign o_gnt[PORT_DM] = i_req_dm & (~i_req_if | (i_last == PORT_IF));
    assign o_gnt[PORT_IF] = i_req_if & (~i_req_dm | (i_last == PORT_DM));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between a fetch port and a data port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_done,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy
);
    state_t        r_state;
    state_t        w_next;
    port_t         r_last;
    port_t         r_sel;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_dm_rdata;
    logic [1:0]    w_pick;
    logic          w_take;

    rr_select2 u_rr_select2 (
        .i_req_if (if_req),
        .i_req_dm (dm_req),
        .i_last   (r_last),
        .o_gnt    (w_pick)
    );

    assign w_take    = (r_state == ST_IDLE) && (|w_pick);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state and strobes; grants are gated by rst_n so none escape while reset is held
    always_comb begin
        w_next  = r_state;
        if_gnt  = 1'b0;
        dm_gnt  = 1'b0;
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        if_done = 1'b0;
        dm_done = 1'b0;
        busy    = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if_gnt = rst_n & w_pick[PORT_IF];
                dm_gnt = rst_n & w_pick[PORT_DM];
                w_next = (|w_pick) ? ST_ACCESS : ST_IDLE;
            end
            ST_ACCESS: begin
                mem_en = 1'b1;
                mem_we = r_we;
                w_next = mem_ready ? ST_DONE : ST_ACCESS;
            end
            ST_DONE: begin
                if_done = (r_sel == PORT_IF);
                dm_done = (r_sel == PORT_DM);
                w_next  = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Capture the winner's request, collect read data, and advance the round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= RESET_LAST;
            r_sel      <= PORT_IF;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (w_take) begin
                r_sel   <= w_pick[PORT_DM] ? PORT_DM : PORT_IF;
                r_we    <= w_pick[PORT_DM] & dm_we;
                r_addr  <= w_pick[PORT_DM] ? dm_addr : if_addr;
                r_wdata <= w_pick[PORT_DM] ? dm_wdata : '0;
            end
            if (r_state == ST_ACCESS && mem_ready && !r_we) begin
                if (r_sel == PORT_IF) r_if_rdata <= mem_rdata;
                else                  r_dm_rdata <= mem_rdata;
            end
            if (r_state == ST_DONE) r_last <= r_sel;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_gnt, if_done;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_done;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_en, mem_we, mem_ready, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] env_mem [16];
    logic [31:0] ref_mem [16];

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_done   (dm_done),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        if_req    = 1'b0;
        dm_req    = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (busy && c < 20) begin
            sync();
            c++;
        end
        check("idle_wait", busy, 0);
    endtask

    // Random traffic: each port raises a request and holds it until granted; memory stalls randomly
    task automatic run_random(input int cycles);
        bit          if_pend = 0, dm_pend = 0, dm_w = 0, g_if, g_dm, m_we = 0;
        logic [31:0] if_a = 0, dm_a = 0, dm_d = 0, m_addr = 0, m_wdata = 0;
        logic [31:0] exp_if_rd = 0, exp_dm_rd = 0;
        int          m_stage = 0, m_last = 0, m_win = 0, n_txn = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            env_mem[i] = $urandom;
            ref_mem[i] = env_mem[i];
        end
        for (int cyc = 0; cyc < cycles; cyc++) begin
            sync();
            if (!if_pend && $urandom_range(2) == 0) begin
                if_pend = 1;
                if_a    = 32'h100 + ($urandom_range(15) << 2);
            end
            if (!dm_pend && $urandom_range(2) == 0) begin
                dm_pend = 1;
                dm_a    = 32'h100 + ($urandom_range(15) << 2);
                dm_w    = 1'($urandom_range(1));
                dm_d    = $urandom;
            end
            if_req    = if_pend;
            if_addr   = if_a;
            dm_req    = dm_pend;
            dm_addr   = dm_a;
            dm_we     = dm_w;
            dm_wdata  = dm_d;
            mem_ready = ($urandom_range(3) != 0);
            mem_rdata = env_mem[mem_addr[5:2]];
            @(negedge clk);
            g_if = 0;
            g_dm = 0;
            if (m_stage == 0) begin
                if (if_pend && dm_pend) begin
                    if (m_last == 0) g_dm = 1;
                    else             g_if = 1;
                end else begin
                    g_if = if_pend;
                    g_dm = dm_pend;
                end
            end
            check("r_gnt", {if_gnt, dm_gnt}, {g_if, g_dm});
            check("r_busy", busy, m_stage != 0);
            check("r_mem_en", mem_en, m_stage == 1);
            if (m_stage == 1) begin
                check("r_addr", mem_addr, m_addr);
                check("r_we", mem_we, m_we);
                if (m_we) check("r_wdata", mem_wdata, m_wdata);
            end
            check("r_done", {if_done, dm_done}, {m_stage == 2 && m_win == 0, m_stage == 2 && m_win == 1});
            check("r_rdata", {if_rdata, dm_rdata}, {exp_if_rd, exp_dm_rd});
            if (mem_en && mem_we && mem_ready) env_mem[mem_addr[5:2]] = mem_wdata;
            case (m_stage)
                0: if (g_if || g_dm) begin
                    m_win   = g_dm ? 1 : 0;
                    m_addr  = g_dm ? dm_a : if_a;
                    m_we    = g_dm && dm_w;
                    m_wdata = dm_d;
                    if (g_dm) dm_pend = 0;
                    else      if_pend = 0;
                    m_stage = 1;
                end
                1: if (mem_ready) begin
                    if (m_we)            ref_mem[m_addr[5:2]] = m_wdata;
                    else if (m_win == 1) exp_dm_rd = ref_mem[m_addr[5:2]];
                    else                 exp_if_rd = ref_mem[m_addr[5:2]];
                    m_stage = 2;
                end
                default: begin
                    m_last  = m_win;
                    m_stage = 0;
                    n_txn++;
                end
            endcase
        end
        check("r_progress", n_txn > 100, 1);
    endtask

    initial begin
        logic [3:0] rr_exp;
        int         n_gnt;
        if_req    = 0; if_addr  = 0;
        dm_req    = 0; dm_we    = 0; dm_addr = 0; dm_wdata = 0;
        mem_rdata = 0; mem_ready = 0;
        rst_n     = 0;
        #2;
        if_req = 1;
        dm_req = 1;
        #1;
        check("rst_gnt", {if_gnt, dm_gnt}, 0);
        check("rst_busy", busy, 0);
        check("rst_mem", {mem_en, mem_we}, 0);
        check("rst_regs", {mem_addr, mem_wdata}, 0);
        check("rst_rdata", {if_rdata, dm_rdata}, 0);
        if_req = 0;
        dm_req = 0;
        @(posedge clk);
        #3;
        rst_n = 1;

        // Single fetch with memory always ready
        sync();
        if_req = 1; if_addr = 32'h10; mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        #1;
        check("s1_gnt", {if_gnt, dm_gnt}, 2'b10);
        check("s1_en0", mem_en, 0);
        sync();
        if_req = 0;
        #1;
        check("s1_en", mem_en, 1);
        check("s1_addr", mem_addr, 32'h10);
        check("s1_we", mem_we, 0);
        check("s1_done_early", if_done, 0);
        sync();
        #1;
        check("s1_done", {if_done, dm_done}, 2'b10);
        check("s1_rdata", if_rdata, 32'hDEADBEEF);
        sync();
        #1;
        check("s1_idle", {if_done, busy}, 0);
        check("s1_hold", if_rdata, 32'hDEADBEEF);

        // Both ports hammering after reset alternate starting with the data port
        do_reset();
        if_req = 1; dm_req = 1; if_addr = 32'h40; dm_addr = 32'h44; dm_we = 0;
        mem_ready = 1; mem_rdata = 32'h12345678;
        rr_exp = 4'b0101;
        n_gnt  = 0;
        for (int c = 0; c < 30 && n_gnt < 4; c++) begin
            #1;
            if (if_gnt || dm_gnt) begin
                check("rr_order", dm_gnt, rr_exp[n_gnt]);
                check("rr_onehot", if_gnt & dm_gnt, 0);
                n_gnt++;
            end
            sync();
        end
        check("rr_count", n_gnt, 4);
        if_req = 0;
        dm_req = 0;
        wait_idle();

        // Data write stalled by memory for three cycles
        dm_req = 1; dm_we = 1; dm_addr = 32'h20; dm_wdata = 32'h5A5A5A5A;
        mem_ready = 0; mem_rdata = 32'hFFFF0000;
        #1;
        check("s3_gnt", {if_gnt, dm_gnt}, 2'b01);
        sync();
        dm_req = 0;
        for (int c = 0; c < 4; c++) begin
            mem_ready = (c == 3);
            #1;
            check("s3_en", {mem_en, mem_we}, 2'b11);
            check("s3_addr", mem_addr, 32'h20);
            check("s3_wdata", mem_wdata, 32'h5A5A5A5A);
            check("s3_nodone", dm_done, 0);
            sync();
        end
        mem_ready = 0;
        #1;
        check("s3_done", {if_done, dm_done}, 2'b01);
        check("s3_en_off", mem_en, 0);
        check("s3_rdata_hold", dm_rdata, 32'h12345678);
        sync();
        #1;
        check("s3_pulse", dm_done, 0);

        // Reset pulse in the middle of a stalled read
        dm_req = 1; dm_we = 0; dm_addr = 32'h30; mem_ready = 0;
        #1;
        check("s4_gnt", dm_gnt, 1);
        sync();
        dm_req = 0;
        #1;
        check("s4_en", mem_en, 1);
        #1;
        rst_n = 0;
        #1;
        check("s4_async", {mem_en, busy}, 0);
        check("s4_rdata_clr", dm_rdata, 0);
        mem_ready = 1;
        @(posedge clk);
        #3;
        rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("s4_nodone", {if_done, dm_done}, 0);
            sync();
        end
        if_req = 1; dm_req = 1;
        #1;
        check("s4_prio", {if_gnt, dm_gnt}, 2'b01);
        sync();
        if_req = 0;
        dm_req = 0;
        wait_idle();

        // Stray memory ready while idle
        mem_ready = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("s5_idle", {busy, mem_en, if_done, dm_done}, 0);
            sync();
        end

        run_random(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 32, address width in bits.
REQ-002 Parameter DW, 32, data width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  instruction-fetch port requests a read.
REQ-006 if_addr  input  AW  fetch address, valid while if_req=1.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_done  output  1  one-cycle pulse; if_rdata is valid.
REQ-009 if_rdata  output  DW  fetched instruction word.
REQ-010 dm_req  input  1  data port requests an access.
REQ-011 dm_we  input  1  data access is a write (1) or read (0).
REQ-012 dm_addr  input  AW  data address, valid while dm_req=1.
REQ-013 dm_wdata  input  DW  write data, valid while dm_req=1 and dm_we=1.
REQ-014 dm_gnt  output  1  data request accepted this cycle.
REQ-015 dm_done  output  1  one-cycle pulse; access complete, dm_rdata valid on reads.
REQ-016 dm_rdata  output  DW  read data.
REQ-017 mem_en  output  1  access strobe to the shared single-port memory.
REQ-018 mem_we  output  1  write strobe, qualified by mem_en.
REQ-019 mem_addr, mem_wdata  output  AW, DW  registered address and write data.
REQ-020 mem_rdata  input  DW  memory read data, valid when mem_ready=1.
REQ-021 mem_ready  input  1  memory completes the current access this cycle.
REQ-022 busy  output  1  arbiter is not in IDLE.

Function
REQ-023 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-024 IDLE, at least one req high: grant exactly one port, combinationally (gnt in the same cycle); capture its addr, we and wdata; move to ACCESS.
REQ-025 Winner selection SHALL be round-robin: when both ports request, the port not served last wins; after reset the data port has priority.
REQ-026 if_gnt and dm_gnt SHALL be mutually exclusive and asserted only in IDLE.
REQ-027 ACCESS: mem_en=1, with mem_we/mem_addr/mem_wdata held stable from the captured values; on mem_ready=1, capture mem_rdata into the winner's rdata register and move to DONE.
REQ-028 ACCESS with mem_ready=0: remain in ACCESS indefinitely, outputs unchanged.
REQ-029 DONE: pulse the winner's done for exactly one cycle, update the last-served pointer, return to IDLE.
REQ-030 Minimum latency: gnt in cycle N, mem_en in N+1, done in N+2 when mem_ready=1 in N+1; peak throughput is one access per 3 cycles.
REQ-031 Requests arriving outside IDLE SHALL be ignored until IDLE; a requester holds req until it sees gnt.
REQ-032 if_rdata and dm_rdata SHALL hold their last value until the next completed read on that port.
REQ-033 mem_we SHALL never be 1 for a fetch-port access.
REQ-034 mem_ready while not in ACCESS SHALL be ignored.

Reset
REQ-035 rst_n=0 SHALL immediately force state=IDLE, priority=data, and mem_en, mem_we, gnt, done and busy to 0; all data and address registers to 0.
REQ-036 Reset during ACCESS or DONE SHALL abort the access with no done pulse.

Structure
REQ-037 The state encoding (IDLE, ACCESS, DONE) and the port identifiers (IF, DM) SHALL live in the shared CPU package.
REQ-038 The round-robin two-way selector SHALL be a sub-module rr_select2 (inputs: two reqs and a last-served bit; output: one-hot grant).

Verification
REQ-039 Scenario: if_req=1, if_addr=0x10, mem_ready tied 1, mem_rdata=0xDEADBEEF -> if_gnt in cycle 0, mem_en in cycle 1 with mem_addr=0x10, if_done in cycle 2 with if_rdata=0xDEADBEEF.
REQ-040 Scenario: both reqs held high for 4 accesses after reset -> grant order DM, IF, DM, IF.
REQ-041 Scenario: dm write, addr=0x20, wdata=0x5A5A5A5A, mem_ready low for 3 cycles -> mem_en/mem_we/addr/wdata stable for 4 cycles, dm_done 1 cycle after mem_ready.
REQ-042 Scenario: rst_n pulsed low during ACCESS -> mem_en falls without waiting for clk, no done pulse, next simultaneous request granted to DM.
REQ-043 Scenario: mem_ready=1 while IDLE with no reqs -> no state change, no done, busy=0.
